udp_pkt_gen: RTL and testbench

// Parametrised IPv4/UDP test-packet source for the eth_send MAC framer. Periodically launches a packet,

---
 rtl/udp_pkt_gen_if.sv | 19 +
 rtl/udp_pkt_gen.sv | 210 +++++++++++++++++++++
 tb/tb_udp_pkt_gen.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_pkt_gen_if.sv
// udp_pkt_gen_if: byte-serving handshake between the UDP test-packet source
// (master) and the eth_send MAC framer (slave).
interface udp_pkt_gen_if;
   logic        tx_go;
   logic [15:0] data_length;
   logic        fifo_rdreq;
   logic [7:0]  fifo_rddata;
   logic        send_done;

   modport master (
      output tx_go, data_length, fifo_rddata,
      input  fifo_rdreq, send_done
   );

   modport slave (
      input  tx_go, data_length, fifo_rddata,
      output fifo_rdreq, send_done
   );
endinterface

// File: rtl/udp_pkt_gen.sv
// udp_pkt_gen: periodic IPv4/UDP test-packet source for eth_send.
// Computes the IP header checksum word-serially before each launch and sweeps
// the payload length LEN_MIN..LEN_MAX. Define UDP_CKSUM_EN to also compute the
// UDP checksum (pseudo-header + UDP header + payload); otherwise it is sent as 0.
module udp_pkt_gen #(
   parameter logic [31:0] SRC_IP   = 32'hC0A80002,
   parameter logic [31:0] DST_IP   = 32'hC0A80003,
   parameter logic [15:0] SRC_PORT = 16'd5000,
   parameter logic [15:0] DST_PORT = 16'd6102,
   parameter logic [7:0]  TTL      = 8'h40,
   parameter logic [15:0] LEN_MIN  = 16'd22,
   parameter logic [15:0] LEN_MAX  = 16'd28,
   parameter logic [23:0] GAP_CYC  = 24'd1000,
   parameter logic [23:0] TIMEOUT  = 24'd65535
) (
   input  logic          gmii_tx_clk,
   input  logic          rst,
   udp_pkt_gen_if.master bus,
   output logic [15:0]   pkt_cnt,
   output logic          timeout_err
);

   typedef enum logic [1:0] {IDLE, CALC, GO, SEND} state_t;

   state_t      state;
   logic [23:0] gap_cnt;
   logic [23:0] wd_cnt;
   logic [10:0] calc_idx;
   logic [31:0] sum;
   logic [31:0] sum_next;
   logic [15:0] calc_word;
   logic [15:0] len;
   logic [15:0] idx;
   logic [15:0] pay_idx;
   logic [15:0] tot_len;
   logic [15:0] udp_len;
   logic [15:0] ip_csum;
   logic [15:0] udp_csum;
   logic        tx_go;
   logic [7:0]  rd_byte;

   assign tot_len          = len + 16'd28;
   assign udp_len          = len + 16'd8;
   assign pay_idx          = idx - 16'd28;
   assign sum_next         = sum + {16'h0000, calc_word};
   assign bus.tx_go        = tx_go;
   assign bus.data_length  = tot_len;
   assign bus.fifo_rddata  = rd_byte;

   function automatic logic [15:0] fold16(input logic [31:0] s);
      logic [31:0] f;
      f = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
      f = {16'h0000, f[15:0]} + {16'h0000, f[31:16]};
      return f[15:0];
   endfunction

`ifdef UDP_CKSUM_EN
   logic [15:0] calc_last;
   logic [15:0] pw_off;
   logic [15:0] pw_lo_idx;

   assign calc_last = 16'd19 + ((len + 16'd1) >> 1);
   assign pw_off    = {4'b0000, calc_idx - 11'd20, 1'b0};
   assign pw_lo_idx = pw_off + 16'd1;
`else
   assign udp_csum = '0;
`endif

   // Checksum word fed to the accumulator for the current CALC step
   always_comb begin
      calc_word = '0;
      case (calc_idx)
         11'd0:  calc_word = 16'h4500;
         11'd1:  calc_word = tot_len;
         11'd4:  calc_word = {TTL, 8'h11};
         11'd6:  calc_word = SRC_IP[31:16];
         11'd7:  calc_word = SRC_IP[15:0];
         11'd8:  calc_word = DST_IP[31:16];
         11'd9:  calc_word = DST_IP[15:0];
`ifdef UDP_CKSUM_EN
         11'd10: calc_word = SRC_IP[31:16];
         11'd11: calc_word = SRC_IP[15:0];
         11'd12: calc_word = DST_IP[31:16];
         11'd13: calc_word = DST_IP[15:0];
         11'd14: calc_word = 16'h0011;
         11'd15: calc_word = udp_len;
         11'd16: calc_word = SRC_PORT;
         11'd17: calc_word = DST_PORT;
         11'd18: calc_word = udp_len;
         11'd19: calc_word = 16'h0000;
         default: begin
            if (calc_idx >= 11'd20) begin
               calc_word[15:8] = pkt_cnt[7:0] + pw_off[7:0];
               if (pw_lo_idx < len)
                  calc_word[7:0] = pkt_cnt[7:0] + pw_lo_idx[7:0];
            end
         end
`else
         default: calc_word = '0;
`endif
      endcase
   end

   // Show-ahead byte map: header, then payload, then zero fill
   always_comb begin
      rd_byte = 8'h00;
      case (idx)
         16'd0:  rd_byte = 8'h45;
         16'd2:  rd_byte = tot_len[15:8];
         16'd3:  rd_byte = tot_len[7:0];
         16'd8:  rd_byte = TTL;
         16'd9:  rd_byte = 8'h11;
         16'd10: rd_byte = ip_csum[15:8];
         16'd11: rd_byte = ip_csum[7:0];
         16'd12: rd_byte = SRC_IP[31:24];
         16'd13: rd_byte = SRC_IP[23:16];
         16'd14: rd_byte = SRC_IP[15:8];
         16'd15: rd_byte = SRC_IP[7:0];
         16'd16: rd_byte = DST_IP[31:24];
         16'd17: rd_byte = DST_IP[23:16];
         16'd18: rd_byte = DST_IP[15:8];
         16'd19: rd_byte = DST_IP[7:0];
         16'd20: rd_byte = SRC_PORT[15:8];
         16'd21: rd_byte = SRC_PORT[7:0];
         16'd22: rd_byte = DST_PORT[15:8];
         16'd23: rd_byte = DST_PORT[7:0];
         16'd24: rd_byte = udp_len[15:8];
         16'd25: rd_byte = udp_len[7:0];
         16'd26: rd_byte = udp_csum[15:8];
         16'd27: rd_byte = udp_csum[7:0];
         default: begin
            if (idx >= 16'd28 && idx < tot_len)
               rd_byte = pkt_cnt[7:0] + pay_idx[7:0];
         end
      endcase
   end

   // Packet FSM: gap timer, checksum accumulation, launch, serve/watchdog
   always_ff @(posedge gmii_tx_clk) begin
      if (rst) begin
         state       <= IDLE;
         tx_go       <= 1'b0;
         pkt_cnt     <= '0;
         timeout_err <= 1'b0;
         len         <= LEN_MIN;
         gap_cnt     <= '0;
         wd_cnt      <= '0;
         idx         <= '0;
         calc_idx    <= '0;
         sum         <= '0;
         ip_csum     <= '0;
`ifdef UDP_CKSUM_EN
         udp_csum    <= '0;
`endif
      end else begin
         idx <= (state == SEND && bus.fifo_rdreq) ? idx + 16'd1 : 16'd0;
         case (state)
            IDLE: begin
               if (gap_cnt == GAP_CYC - 24'd1) begin
                  gap_cnt  <= '0;
                  calc_idx <= '0;
                  sum      <= '0;
                  state    <= CALC;
               end else begin
                  gap_cnt <= gap_cnt + 24'd1;
               end
            end
            CALC: begin
               calc_idx <= calc_idx + 11'd1;
               sum      <= sum_next;
               // IP checksum latches after word 9; the UDP sum restarts from zero
               if (calc_idx == 11'd9) begin
                  ip_csum <= ~fold16(sum_next);
`ifdef UDP_CKSUM_EN
                  sum     <= '0;
               end else if ({5'b00000, calc_idx} == calc_last) begin
                  udp_csum <= (fold16(sum_next) == 16'hFFFF) ? 16'hFFFF : ~fold16(sum_next);
                  tx_go    <= 1'b1;
                  state    <= GO;
`else
                  tx_go   <= 1'b1;
                  state   <= GO;
`endif
               end
            end
            GO: begin
               tx_go  <= 1'b0;
               wd_cnt <= '0;
               state  <= SEND;
            end
            SEND: begin
               if (bus.send_done) begin
                  pkt_cnt <= pkt_cnt + 16'd1;
                  len     <= (len >= LEN_MAX) ? LEN_MIN : len + 16'd1;
                  gap_cnt <= '0;
                  state   <= IDLE;
               end else if (wd_cnt == TIMEOUT - 24'd1) begin
                  timeout_err <= 1'b1;
                  gap_cnt     <= '0;
                  state       <= IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 24'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_pkt_gen.sv
// tb_udp_pkt_gen: directed bench for udp_pkt_gen with hand-derived expectations.
module tb_udp_pkt_gen;

   localparam logic [31:0] SRC_IP   = 32'hC0A80002;
   localparam logic [31:0] DST_IP   = 32'hC0A80003;
   localparam logic [15:0] SRC_PORT = 16'd5000;
   localparam logic [15:0] DST_PORT = 16'd6102;
   localparam logic [7:0]  TTL      = 8'h40;
   localparam int          GAP      = 1000;
   localparam int          TMO      = 3000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pkt_cnt;
   logic        timeout_err;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  got [0:127];

   udp_pkt_gen_if bus ();

   udp_pkt_gen #(
      .SRC_IP(SRC_IP), .DST_IP(DST_IP), .SRC_PORT(SRC_PORT), .DST_PORT(DST_PORT),
      .TTL(TTL), .LEN_MIN(16'd22), .LEN_MAX(16'd28),
      .GAP_CYC(24'd1000), .TIMEOUT(24'd3000)
   ) dut (
      .gmii_tx_clk(clk),
      .rst(rst),
      .bus(bus),
      .pkt_cnt(pkt_cnt),
      .timeout_err(timeout_err)
   );

   always #4 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ocfold(input logic [31:0] s0);
      logic [31:0] s;
      s = s0;
      while (s[31:16] != 16'h0000) s = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
      return s[15:0];
   endfunction

   function automatic logic [15:0] ref_ip(input logic [15:0] tl);
      logic [31:0] s;
      s = 32'h4500 + {16'h0, tl} + {16'h0, TTL, 8'h11}
        + {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
        + {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]};
      return ~ocfold(s);
   endfunction

   function automatic logic [15:0] ref_udp(input int plen, input int pcnt);
`ifdef UDP_CKSUM_EN
      logic [31:0] s;
      logic [15:0] ul;
      logic [15:0] r;
      logic [7:0]  b;
      ul = 16'(plen + 8);
      s = {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
        + {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]}
        + 32'h0011 + {16'h0, ul} + {16'h0, SRC_PORT} + {16'h0, DST_PORT} + {16'h0, ul};
      for (int i = 0; i < plen; i++) begin
         b = 8'(pcnt + i);
         if (i % 2 == 0) s = s + {16'h0, b, 8'h00};
         else            s = s + {24'h0, b};
      end
      r = ~ocfold(s);
      return (r == 16'h0000) ? 16'hFFFF : r;
`else
      if (plen < 0 || pcnt < 0) return 16'hDEAD;
      return 16'h0000;
`endif
   endfunction

   // Cycle index (1 = first cycle after reset/send_done) at which tx_go is seen
   function automatic int exp_gap(input int plen);
`ifdef UDP_CKSUM_EN
      return GAP + 10 + 10 + (plen + 1) / 2 + 1;
`else
      if (plen < 0) return 0;
      return GAP + 10 + 1;
`endif
   endfunction

   function automatic logic [7:0] exp_byte(input int k, input int plen, input int pcnt);
      logic [15:0] tl, ul, ic, uc;
      logic [7:0]  pc;
      tl = 16'(plen + 28);
      ul = 16'(plen + 8);
      ic = ref_ip(tl);
      uc = ref_udp(plen, pcnt);
      pc = 8'(pcnt);
      if (k < 28) begin
         case (k)
            0:  return 8'h45;
            2:  return tl[15:8];
            3:  return tl[7:0];
            8:  return TTL;
            9:  return 8'h11;
            10: return ic[15:8];
            11: return ic[7:0];
            12: return SRC_IP[31:24];
            13: return SRC_IP[23:16];
            14: return SRC_IP[15:8];
            15: return SRC_IP[7:0];
            16: return DST_IP[31:24];
            17: return DST_IP[23:16];
            18: return DST_IP[15:8];
            19: return DST_IP[7:0];
            20: return SRC_PORT[15:8];
            21: return SRC_PORT[7:0];
            22: return DST_PORT[15:8];
            23: return DST_PORT[7:0];
            24: return ul[15:8];
            25: return ul[7:0];
            26: return uc[15:8];
            27: return uc[7:0];
            default: return 8'h00;
         endcase
      end else if (k < plen + 28) begin
         return pc + 8'(k - 28);
      end
      return 8'h00;
   endfunction

   // exp_cyc=0: only require that tx_go shows up within the bound
   task automatic wait_go(input int exp_cyc, input string tag);
      int cyc;
      cyc = 1;
      while (bus.tx_go !== 1'b1 && cyc < 20000) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (exp_cyc > 0) check(tag, 32'(cyc), 32'(exp_cyc));
      else             check(tag, {31'h0, bus.tx_go}, 32'h1);
   endtask

   task automatic serve(input int nbytes, input int plen, input int pcnt, input string tag);
      @(posedge clk); #1;
      check({tag, "_go_pulse"}, {31'h0, bus.tx_go}, 32'h0);
      bus.fifo_rdreq = 1'b1;
      for (int k = 0; k < nbytes; k++) begin
         got[k] = bus.fifo_rddata;
         check($sformatf("%s_b%0d", tag, k), {24'h0, bus.fifo_rddata}, {24'h0, exp_byte(k, plen, pcnt)});
         @(posedge clk); #1;
      end
      bus.fifo_rdreq = 1'b0;
   endtask

   task automatic pulse_done();
      bus.send_done = 1'b1;
      @(posedge clk); #1;
      bus.send_done = 1'b0;
   endtask

   initial begin
      int plen;
      int t;
      bus.fifo_rdreq = 1'b0;
      bus.send_done  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_go",   {31'h0, bus.tx_go},     32'h0);
      check("rst_pkt_cnt", {16'h0, pkt_cnt},       32'h0);
      check("rst_tmo",     {31'h0, timeout_err},   32'h0);
      check("rst_rddata",  {24'h0, bus.fifo_rddata}, 32'h45);
      check("rst_len",     {16'h0, bus.data_length}, 32'd50);
      rst = 1'b0;

      // first packet: launch latency, header map, payload and trailing zeros
      wait_go(exp_gap(22), "go_lat0");
      check("dlen0", {16'h0, bus.data_length}, 32'd50);
      serve(78, 22, 0, "p0");
      check("p0_totlen", {16'h0, got[2], got[3]}, 32'h0032);
`ifndef UDP_CKSUM_EN
      check("p0_ipcsum", {16'h0, got[10], got[11]}, 32'hF965);
`endif
      check("p0_pay0",  {24'h0, got[28]}, 32'h00);
      check("p0_pay21", {24'h0, got[49]}, 32'h15);
      check("p0_tail",  {24'h0, got[50]}, 32'h00);
      pulse_done();
      check("p0_cnt", {16'h0, pkt_cnt}, 32'd1);

      // length sweep 23..28 then wrap to 22
      for (int n = 1; n < 8; n++) begin
         plen = 22 + (n % 7);
         wait_go(exp_gap(plen), $sformatf("go_lat%0d", n));
         check($sformatf("dlen%0d", n), {16'h0, bus.data_length}, 32'(plen + 28));
         serve(plen + 30, plen, n, $sformatf("p%0d", n));
         check($sformatf("p%0d_pay0", n), {24'h0, got[28]}, 32'(n));
`ifdef UDP_CKSUM_EN
         if ({got[26], got[27]} == 16'h0000)
            check($sformatf("p%0d_udp_nz", n), 32'h0, 32'h1);
`endif
         pulse_done();
         check($sformatf("p%0d_cnt", n), {16'h0, pkt_cnt}, 32'(n + 1));
      end

      // watchdog abort: length and count unchanged, send_done outside SEND ignored
      wait_go(exp_gap(23), "go_lat8");
      check("dlen8", {16'h0, bus.data_length}, 32'd51);
      @(posedge clk); #1;
      t = 1;
      while (timeout_err !== 1'b1 && t < TMO + 50) begin
         @(posedge clk); #1;
         t++;
      end
      check("tmo_len_cyc", 32'(t), 32'(TMO + 1));
      check("tmo_cnt", {16'h0, pkt_cnt}, 32'd8);
      pulse_done();
      check("idle_done_ign", {16'h0, pkt_cnt}, 32'd8);
      wait_go(0, "go_after_tmo");
      check("dlen8_retry", {16'h0, bus.data_length}, 32'd51);
      serve(53, 23, 8, "p8");
      pulse_done();
      check("p8_cnt", {16'h0, pkt_cnt}, 32'd9);
      check("tmo_sticky", {31'h0, timeout_err}, 32'h1);

      // reset mid-SEND at byte 15
      wait_go(exp_gap(24), "go_lat9");
      @(posedge clk); #1;
      bus.fifo_rdreq = 1'b1;
      repeat (15) begin
         @(posedge clk); #1;
      end
      check("p9_b15", {24'h0, bus.fifo_rddata}, 32'h02);
      rst = 1'b1;
      @(posedge clk); #1;
      bus.fifo_rdreq = 1'b0;
      check("mrst_tx_go",   {31'h0, bus.tx_go},       32'h0);
      check("mrst_rddata",  {24'h0, bus.fifo_rddata}, 32'h45);
      check("mrst_pkt_cnt", {16'h0, pkt_cnt},         32'h0);
      check("mrst_tmo",     {31'h0, timeout_err},     32'h0);
      check("mrst_len",     {16'h0, bus.data_length}, 32'd50);
      rst = 1'b0;
      wait_go(exp_gap(22), "go_after_rst");

      // send_done coincident with the watchdog expiry: send_done wins
      @(posedge clk); #1;
      t = 1;
      while (t < TMO) begin
         @(posedge clk); #1;
         t++;
      end
      check("tie_pre_tmo", {31'h0, timeout_err}, 32'h0);
      pulse_done();
      check("tie_tmo", {31'h0, timeout_err}, 32'h0);
      check("tie_cnt", {16'h0, pkt_cnt}, 32'd1);
      wait_go(exp_gap(23), "go_after_tie");
      check("tie_dlen", {16'h0, bus.data_length}, 32'd51);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
